encoder_layer_0_attention_self_value_weight_sink: RTL and testbench
===================================================================

Name: encoder_layer_0_attention_self_value_weight_sink

Overview:
Receiving end of the value-weight streaming interface. It accepts the valid/ready beat stream that a weight source produces, with PARALLELISM lanes per beat. It packs each beat into one word of an internal buffer, and flags when one complete tensor pass (IN_DEPTH beats) has been captured. Stored words are read back through a 2-cycle registered read port (address0/ce0/q0), which lets writeback/checker logic and the cocotb bench consume received weights by address.

Parameters:
VALUE_WEIGHT_TENSOR_SIZE_DIM_0, 32, elements per tensor row
VALUE_WEIGHT_TENSOR_SIZE_DIM_1, 1, rows per tensor
VALUE_WEIGHT_PRECISION_0, 16, element width in bits
VALUE_WEIGHT_PRECISION_1, 3, fractional bits (informational only, no arithmetic use)
VALUE_WEIGHT_PARALLELISM_DIM_0, 1, lanes per beat, dim 0
VALUE_WEIGHT_PARALLELISM_DIM_1, 1, lanes per beat, dim 1
IN_DEPTH, TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0, beats per tensor pass, equal to buffer depth
LANES, PARALLELISM_DIM_0*PARALLELISM_DIM_1, lanes per beat (derived)
WORD_W, PRECISION_0*LANES, buffer word width (derived)
ADDR_WIDTH, $clog2(IN_DEPTH)+1, read-address and counter width (derived)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-low
data_in  in  PRECISION_0 x LANES (unpacked array)  lanes of one beat
data_in_valid  in  1  beat valid
data_in_ready  out  1  sink can accept a beat
clear  in  1  single-cycle pulse that rearms the sink for a new pass
full  out  1  one complete pass has been captured
beat_count  out  ADDR_WIDTH  number of beats accepted in the current pass
address0  in  ADDR_WIDTH  read address
ce0  in  1  read enable / pipeline advance
q0  out  WORD_W  read data

Behaviour:
- Reset (rst==0 at a clock edge): state=FILL, wr_ptr=0, beat_count=0, full=0, both q0 pipeline registers=0. data_in_ready is 0 while rst==0. Buffer contents are not reset.
- States:
  - FILL: data_in_ready = !clear.
  - FULL: data_in_ready = 0, full = 1.
- Handshake: a beat is accepted when data_in_valid && data_in_ready at the clock edge.
  - On acceptance, mem[wr_ptr] <= packed beat, with lane j at bits [PRECISION_0*j +: PRECISION_0].
  - On acceptance, wr_ptr and beat_count increment.
  - data_in is ignored when no handshake occurs.
- FILL->FULL: on the beat accepted while wr_ptr==IN_DEPTH-1. In that edge, wr_ptr wraps to 0, beat_count=IN_DEPTH, and full=1 from the next cycle.
- FULL holds until clear. Beats offered in FULL are not accepted, and the buffer and counters do not change.
- clear in either state: next state=FILL, wr_ptr=0, beat_count=0, full=0. Buffer contents are retained, not erased.
- clear has priority over a simultaneous beat. data_in_ready is low in that cycle, so the beat is not accepted and the source must hold it.
- Reset mid-pass: behaves as a clear. The partial pass is abandoned; stale words remain readable.
- Read port:
  - Two-stage registered pipeline, advanced only when ce0==1: t0 <= rd_data(address0); q0 <= t0.
  - Latency is 2 enabled cycles. q0 holds its value while ce0==0.
  - rd_data = mem[address0] if address0 < IN_DEPTH, else 0.
- Read and write are independent. A read of the address being written in the same cycle returns the old word (read-before-write).
- A read during FILL returns whatever is currently stored; reading before full=1 is the consumer's responsibility.
- No ready combinational path from data_in_valid; data_in_ready depends only on state and clear.

Test Plan:
- Reset with defaults, stream 32 beats of 0x1000+i with valid held high. Required: ready high for 32 cycles, then 0; full=1 one cycle after the 32nd beat; beat_count=32. Then address0=5, ce0=1: q0=0x1005 two cycles later.
- Random valid gaps and ce0 stalls during readback. Required: every address 0..31 reads 0x1000+addr; q0 frozen during every ce0=0 cycle.
- In FULL, drive valid=1 with data 0xFFFF for 10 cycles. Required: ready stays 0; mem[0] still reads 0x1000; beat_count stays 32.
- After 10 beats, pulse clear in the same cycle as a valid beat 0xAAAA. Required: beat not accepted, beat_count=0. Refill 32 beats of 0x2000+i, then read addr 9: 0x2009.
- Assert rst low after 7 beats. Required: ready=0, full=0, beat_count=0, q0=0. After release, a fresh 32-beat pass completes normally.
- PARALLELISM_DIM_0=4 (IN_DEPTH=8), lanes {4k+3,4k+2,4k+1,4k}. Required: full after 8 beats; addr 2 reads 0x000B_000A_0009_0008; address0=8 reads 0.

Source files
------------

// File: rtl/encoder_layer_0_attention_self_value_weight_sink_if.sv
// encoder_layer_0_attention_self_value_weight_sink_if: value-weight beat stream (lanes + valid/ready)
//   data_in       PREC x LANES lanes of one beat (master -> slave)
//   data_in_valid beat valid                     (master -> slave)
//   data_in_ready sink can accept a beat         (slave -> master)
interface encoder_layer_0_attention_self_value_weight_sink_if #(
  parameter int PREC  = 16,
  parameter int LANES = 1
);
  logic [PREC-1:0] data_in [LANES];
  logic            data_in_valid;
  logic            data_in_ready;
  modport master (output data_in, data_in_valid, input data_in_ready);
  modport slave (input data_in, data_in_valid, output data_in_ready);
endinterface

// File: rtl/encoder_layer_0_attention_self_value_weight_sink.sv
// encoder_layer_0_attention_self_value_weight_sink: captures one tensor pass of weight beats into a buffer with a 2-stage read port
//   clk, rst (sync, active-low)
//   in_if       slave side of the beat stream; one beat packed per buffer word
//   clear       pulse that rearms the sink for a new pass (wins over a simultaneous beat)
//   full        a complete pass of IN_DEPTH beats has been captured
//   beat_count  beats accepted in the current pass
//   address0/ce0/q0  read port, q0 valid two ce0-enabled cycles after address0
module encoder_layer_0_attention_self_value_weight_sink #(
  parameter  int VALUE_WEIGHT_TENSOR_SIZE_DIM_0  = 32,
  parameter  int VALUE_WEIGHT_TENSOR_SIZE_DIM_1  = 1,
  parameter  int VALUE_WEIGHT_PRECISION_0        = 16,
  parameter  int VALUE_WEIGHT_PRECISION_1        = 3,
  parameter  int VALUE_WEIGHT_PARALLELISM_DIM_0  = 1,
  parameter  int VALUE_WEIGHT_PARALLELISM_DIM_1  = 1,
  localparam int IN_DEPTH   = VALUE_WEIGHT_TENSOR_SIZE_DIM_0 / VALUE_WEIGHT_PARALLELISM_DIM_0,
  localparam int LANES      = VALUE_WEIGHT_PARALLELISM_DIM_0 * VALUE_WEIGHT_PARALLELISM_DIM_1,
  localparam int WORD_W     = VALUE_WEIGHT_PRECISION_0 * LANES,
  localparam int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  encoder_layer_0_attention_self_value_weight_sink_if.slave in_if,
  input  logic                  clear,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] beat_count,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic                  ce0,
  output logic [WORD_W-1:0]     q0
);
  localparam int PW = $clog2(IN_DEPTH);
  // The fractional-bit count is carried only for documentation; reject nonsensical combinations early.
  if (VALUE_WEIGHT_PRECISION_1 >= VALUE_WEIGHT_PRECISION_0 || VALUE_WEIGHT_TENSOR_SIZE_DIM_1 < 1 ||
      VALUE_WEIGHT_TENSOR_SIZE_DIM_0 % VALUE_WEIGHT_PARALLELISM_DIM_0 != 0) begin : g_bad_params
    $error("invalid value-weight sink parameters");
  end
  typedef enum logic {FILL, FULL} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]     t0_q, q0_q, wdata, rd_data;
  logic [WORD_W-1:0]     mem [IN_DEPTH];
  logic                  acc, last;
  assign acc  = in_if.data_in_valid && in_if.data_in_ready;
  assign last = wr_ptr_q == PW'(IN_DEPTH - 1);
  always_ff @(posedge clk)
    if (!rst) state_q <= FILL;
    else state_q <= state_d;
  always_comb
    state_d = clear ? FILL : (state_q == FILL && acc && last) ? FULL : state_q;
  always_comb begin
    in_if.data_in_ready = rst && state_q == FILL && !clear;
    full = state_q == FULL;
  end
  always_comb begin
    wr_ptr_d = clear ? '0 : acc ? (last ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    cnt_d    = clear ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    wdata = '0;
    for (int j = 0; j < LANES; j++) wdata[VALUE_WEIGHT_PRECISION_0*j +: VALUE_WEIGHT_PRECISION_0] = in_if.data_in[j];
  end
  // Out-of-range addresses read as zero rather than aliasing into the buffer.
  assign rd_data = address0 < ADDR_WIDTH'(IN_DEPTH) ? mem[address0[PW-1:0]] : '0;
  always_ff @(posedge clk)
    if (acc) mem[wr_ptr_q] <= wdata;
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      t0_q     <= '0;
      q0_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (ce0) begin
        t0_q <= rd_data;
        q0_q <= t0_q;
      end
    end
  assign beat_count = cnt_q;
  assign q0 = q0_q;
endmodule

// File: tb/tb_encoder_layer_0_attention_self_value_weight_sink.sv
// tb_encoder_layer_0_attention_self_value_weight_sink: checks the default sink against a buffer model and a 4-lane sink against a vector table
module tb_encoder_layer_0_attention_self_value_weight_sink;
  logic clk = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic rst_a, clear_a, ce_a, full_a;
  logic [5:0] addr_a, cnt_a;
  logic [15:0] q0_a;
  logic rst_b, clear_b, ce_b, full_b;
  logic [3:0] addr_b, cnt_b;
  logic [63:0] q0_b;
  encoder_layer_0_attention_self_value_weight_sink_if #(.PREC(16), .LANES(1)) ia ();
  encoder_layer_0_attention_self_value_weight_sink_if #(.PREC(16), .LANES(4)) ib ();
  encoder_layer_0_attention_self_value_weight_sink dut_a (
    .clk(clk), .rst(rst_a), .in_if(ia.slave), .clear(clear_a), .full(full_a),
    .beat_count(cnt_a), .address0(addr_a), .ce0(ce_a), .q0(q0_a));
  encoder_layer_0_attention_self_value_weight_sink #(.VALUE_WEIGHT_PARALLELISM_DIM_0(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_if(ib.slave), .clear(clear_b), .full(full_b),
    .beat_count(cnt_b), .address0(addr_b), .ce0(ce_b), .q0(q0_b));
  // Reference model for dut_a: stored words, beats in this pass, pass-complete flag, read pipeline.
  logic [15:0] mm [32];
  int cnt_m = 0;
  bit full_m = 0;
  logic [15:0] t0_m = 0, q0_m = 0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic step_a(bit v, logic [15:0] d, bit c, int a, bit ce);
    logic [15:0] rd;
    bit rdy;
    ia.data_in[0] = d;
    ia.data_in_valid = v;
    clear_a = c;
    addr_a = 6'(a);
    ce_a = ce;
    #1;
    rdy = rst_a && !full_m && !c;
    chk("a_ready", 64'(ia.data_in_ready), 64'(rdy));
    rd = (a < 32) ? mm[a] : 16'h0;
    @(posedge clk);
    if (!rst_a) begin
      cnt_m = 0; full_m = 0; t0_m = 0; q0_m = 0;
    end else begin
      if (ce) begin q0_m = t0_m; t0_m = rd; end
      if (c) begin cnt_m = 0; full_m = 0; end
      else if (rdy && v) begin
        mm[cnt_m] = d;
        cnt_m++;
        full_m = cnt_m == 32;
      end
    end
    #1;
    chk("a_full", 64'(full_a), 64'(full_m));
    chk("a_beat_count", 64'(cnt_a), 64'(cnt_m));
    chk("a_q0", 64'(q0_a), 64'(q0_m));
  endtask
  task automatic fill_a(logic [15:0] base, int n, bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step_a(0, 16'($urandom), 0, 0, 0);
      step_a(1, base + 16'(i), 0, 0, 0);
    end
  endtask
  task automatic read_a(int a);
    step_a(0, 0, 0, a, 1);
    step_a(0, 0, 0, a, 1);
  endtask
  task automatic step_b(bit v, bit c, int k, bit erdy, bit efull, int ecnt);
    for (int j = 0; j < 4; j++) ib.data_in[j] = 16'(4 * k + j);
    ib.data_in_valid = v;
    clear_b = c;
    #1;
    chk("b_ready", 64'(ib.data_in_ready), 64'(erdy));
    @(posedge clk);
    #1;
    chk("b_full", 64'(full_b), 64'(efull));
    chk("b_beat_count", 64'(cnt_b), 64'(ecnt));
  endtask
  typedef struct {bit v; bit c; int k; bit rdy; bit full; int cnt;} vec_t;
  vec_t tbl [11];
  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 0, i, 1, i == 7, i + 1};
    tbl[8]  = '{1, 0, 50, 0, 1, 8};
    tbl[9]  = '{1, 1, 60, 0, 0, 0};
    tbl[10] = '{1, 0, 20, 1, 0, 1};
    for (int i = 0; i < 32; i++) mm[i] = 'x;
    rst_a = 0; rst_b = 0;
    clear_b = 0; ce_b = 0; addr_b = 0; ib.data_in_valid = 0;
    for (int j = 0; j < 4; j++) ib.data_in[j] = 0;
    step_a(1, 16'h1234, 0, 0, 1);
    step_a(1, 16'h1234, 0, 0, 1);
    chk("b_rst_full", 64'(full_b), 0);
    chk("b_rst_count", 64'(cnt_b), 0);
    chk("b_rst_q0", q0_b, 0);
    chk("b_rst_ready", 64'(ib.data_in_ready), 0);
    rst_a = 1; rst_b = 1;
    step_a(0, 0, 0, 0, 0);
    // 4-lane sink: fill, offer in FULL, clear, first beat of next pass
    for (int i = 0; i < 11; i++) step_b(tbl[i].v, tbl[i].c, tbl[i].k, tbl[i].rdy, tbl[i].full, tbl[i].cnt);
    ib.data_in_valid = 0;
    addr_b = 2; ce_b = 1;
    repeat (2) @(posedge clk);
    #1 chk("b_read_addr2", q0_b, 64'h000B_000A_0009_0008);
    addr_b = 8;
    repeat (2) @(posedge clk);
    #1 chk("b_read_addr8", q0_b, 0);
    addr_b = 0;
    repeat (2) @(posedge clk);
    #1 chk("b_read_addr0", q0_b, 64'h0053_0052_0051_0050);
    ce_b = 0;
    // default sink: full streaming pass with valid held high
    fill_a(16'h1000, 32, 0);
    chk("a_full_after_32", 64'(full_a), 1);
    chk("a_count_32", 64'(cnt_a), 32);
    step_a(1, 16'hFFFF, 0, 0, 0);
    read_a(5);
    chk("a_read5", 64'(q0_a), 64'h1005);
    // readback with ce0 stalls and wandering addresses while stalled
    for (int a = 0; a < 32; a++) begin
      repeat ($urandom_range(0, 2)) step_a($urandom_range(0, 1), 16'($urandom), 0, $urandom_range(0, 63), 0);
      step_a(0, 0, 0, a, 1);
    end
    read_a(40);
    chk("a_read_oob", 64'(q0_a), 0);
    // beats offered while FULL are dropped
    repeat (10) step_a(1, 16'hFFFF, 0, 0, 1);
    chk("a_mem0_kept", 64'(q0_a), 64'h1000);
    chk("a_count_held", 64'(cnt_a), 32);
    // clear wins over a simultaneous beat
    step_a(0, 0, 1, 0, 0);
    fill_a(16'h7000, 10, 1);
    step_a(1, 16'hAAAA, 1, 0, 0);
    chk("a_clear_count", 64'(cnt_a), 0);
    fill_a(16'h2000, 32, 1);
    chk("a_refill_full", 64'(full_a), 1);
    read_a(9);
    chk("a_read9", 64'(q0_a), 64'h2009);
    // reset mid-pass
    step_a(0, 0, 1, 0, 0);
    fill_a(16'h3000, 7, 0);
    rst_a = 0;
    step_a(1, 16'h5555, 0, 3, 1);
    step_a(1, 16'h5555, 0, 3, 1);
    chk("a_rst_ready", 64'(ia.data_in_ready), 0);
    chk("a_rst_full", 64'(full_a), 0);
    chk("a_rst_count", 64'(cnt_a), 0);
    chk("a_rst_q0", 64'(q0_a), 0);
    rst_a = 1;
    fill_a(16'h4000, 32, 1);
    chk("a_post_rst_full", 64'(full_a), 1);
    repeat (40) step_a($urandom_range(0, 1), 16'($urandom), 0, $urandom_range(0, 35), $urandom_range(0, 1));
    read_a(31);
    chk("a_read31", 64'(q0_a), 64'h401F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
